instr_fetch_stage: RTL and testbench
====================================

Name: instr_fetch_stage

Overview:
- Front-end stage of the pipelined CPU.
- Generates the PC, reads the word-addressed instruction memory and buffers fetched words in a small prefetch FIFO.
- Hands instructions to the decode stage with a valid/ready handshake.
- Supports pipeline flush/redirect from downstream (branch/jump resolution) and back-pressure from decode stalls.

Parameters:
- PC_W, 8, PC/instruction-memory address width in words.
- INSTR_W, 32, instruction width. Format: [31:29] opcode, [28:25] rs1, [24:21] rs2, [20:17] rd, [16:0] zero.
- FIFO_DEPTH, 4, prefetch buffer entries; power of two, minimum 2.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  read request to instruction memory this cycle
- imem_addr  out  PC_W  read address (word index)
- imem_rdata  in  INSTR_W  read data; valid exactly 1 cycle after imem_req
- redirect_valid  in  1  flush pipeline and restart fetch at redirect_pc
- redirect_pc  in  PC_W  new fetch address
- id_ready  in  1  decode stage accepts an instruction this cycle
- if_valid  out  1  if_instr/if_pc hold a valid instruction
- if_instr  out  INSTR_W  instruction to decode
- if_pc  out  PC_W  address of if_instr
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current buffer occupancy (debug/perf)

Behaviour:
- Reset (asynchronous, active-high): pc=RESET_PC; FIFO empty; outstanding flag 0; state RUN.
  - Output reset values: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, fifo_count=0.
- Memory timing: fixed 1-cycle latency. A request at cycle t returns imem_rdata at t+1, captured by an internal pend flag and pend_pc register.
- Issue rule: imem_req=1 when state==RUN, no redirect this cycle, and (fifo_count + pend) < FIFO_DEPTH after accounting for a pop this cycle.
  - On issue: imem_addr=pc and pc<=pc+1.
  - PC wraps modulo 2^PC_W with no flag.
- Capture: when pend==1, push {imem_rdata, pend_pc} into the FIFO at the edge ending cycle t+1.
- Output: show-ahead FIFO, registered.
  - if_valid=1 while FIFO is non-empty; if_instr/if_pc come from the head entry.
  - Pop when if_valid && id_ready.
  - Payload is held stable while if_valid && !id_ready.
- Simultaneous push and pop: allowed; count is unchanged. A push into a full FIFO never occurs because the issue rule guarantees space.
- Throughput: one instruction per cycle sustained when id_ready is held high.
- First instruction: rst falls before edge E0.
  - E0: request for RESET_PC.
  - E1: data pushed.
  - if_valid=1 in the cycle after E1.
- Redirect (highest priority): redirect_valid at cycle t causes, on that edge:
  - FIFO cleared and pend cleared, so the in-flight response is discarded.
  - pc<=redirect_pc.
  - No request issued in cycle t. if_valid is 0 in cycle t+1; the first request to redirect_pc is issued in cycle t+1.
  - A pop coinciding with a redirect is still counted as accepted by decode.
- States:
  - RUN: normal fetch.
  - HALT: only when HALT_DETECT_EN is defined; see Optional Feature.
  - Redirect forces RUN from any state.
- Reset asserted mid-operation: immediate return to reset values; in-flight data discarded.

Optional Feature:
- Macro HALT_DETECT_EN.
- Defined:
  - A captured instruction with opcode 3'b111 is pushed normally, then state<=HALT.
  - Requests issued before detection are still captured.
  - In HALT no further requests are issued. The FIFO continues to drain to decode.
  - Only redirect_valid or rst leaves HALT.
- Undefined: opcode 3'b111 is ordinary data; no HALT state exists and fetch never stops on its own.

Test Plan:
- Reset/first fetch: imem[0]=0x64020000, imem[1]=0x02860000, id_ready=1, release rst → imem_addr 0,1,2,… on consecutive cycles; if_valid rises 2 edges after release with if_instr=0x64020000, if_pc=0, then 0x02860000, if_pc=1 next cycle.
- Back-pressure: id_ready=0 for 10 cycles after start → fifo_count saturates at 4, imem_req drops to 0, if_instr holds 0x64020000; id_ready=1 → pcs 0,1,2,3,4… delivered in order with no loss or duplication.
- Redirect: redirect_valid with redirect_pc=0x40 while FIFO holds 3 entries and a request is in flight → next cycle if_valid=0 and fifo_count=0, imem_addr=0x40; the next if_pc seen is 0x40; the stale in-flight word never appears.
- Wrap-around: redirect_pc=0xFE with PC_W=8 → delivered pcs 0xFE, 0xFF, 0x00, 0x01.
- Async reset mid-stream: assert rst between edges with a full FIFO → if_valid, imem_req and fifo_count go to 0 without waiting for a clock edge; after release, fetch restarts at RESET_PC.
- HALT_DETECT_EN: imem[3]=0xE0000000 → instructions 0–3 delivered, no request beyond addr 4; redirect to 0 restarts fetch from 0.

Source files
------------

// File: rtl/instr_fetch_stage_if.sv
// Fetch-stage bus: instruction-memory read port, redirect input and the
// valid/ready hand-off to decode. The fetch stage uses the master modport.
interface instr_fetch_stage_if #(
  parameter int PC_W       = 8,
  parameter int INSTR_W    = 32,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               id_ready;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;
  logic [CW-1:0]      fifo_count;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, fifo_count,
    input  imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, fifo_count,
    output imem_rdata, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction fetch: PC generation, 1-cycle-latency imem reads, show-ahead
// prefetch FIFO to decode, redirect flush. Optional HALT_DETECT_EN stops fetch on opcode 3'b111.
module instr_fetch_stage #(
  parameter int              PC_W       = 8,
  parameter int              INSTR_W    = 32,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC   = {PC_W{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_stage_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_V = CW'(FIFO_DEPTH);

`ifdef HALT_DETECT_EN
  typedef enum logic [0:0] {RUN = 1'b0, HALT = 1'b1} state_t;
`else
  typedef enum logic [0:0] {RUN = 1'b0} state_t;
`endif

  state_t             state_r;
  logic [PC_W-1:0]    pc_r;
  logic               pend_r;
  logic [PC_W-1:0]    pend_pc_r;
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [CW-1:0]      count_r;
  logic [INSTR_W-1:0] instr_mem_r [FIFO_DEPTH];
  logic [PC_W-1:0]    pc_mem_r    [FIFO_DEPTH];

  logic               pop_s;
  logic               push_s;
  logic [CW-1:0]      occ_s;
  logic               issue_s;

  // Issue decision: occupancy after this edge (push of the pending word,
  // minus any pop) must leave a slot for the word requested now.
  // rst gates the request so imem_req drops the moment reset asserts.
  always_comb begin
    pop_s   = 1'b0;
    push_s  = 1'b0;
    occ_s   = {CW{1'b0}};
    issue_s = 1'b0;
    pop_s   = (count_r != {CW{1'b0}}) && bus.id_ready;
    push_s  = pend_r;
    occ_s   = count_r + CW'(pend_r) - CW'(pop_s);
    if (!rst && (state_r == RUN) && !bus.redirect_valid && (occ_s < DEPTH_V)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // PC, in-flight tracking, prefetch FIFO and run/halt state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= RUN;
      pc_r      <= RESET_PC;
      pend_r    <= 1'b0;
      pend_pc_r <= {PC_W{1'b0}};
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      count_r   <= {CW{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem_r[i] <= {INSTR_W{1'b0}};
        pc_mem_r[i]    <= {PC_W{1'b0}};
      end
    end else if (bus.redirect_valid) begin
      // Flush: the in-flight response is dropped by clearing pend.
      state_r  <= RUN;
      pc_r     <= bus.redirect_pc;
      pend_r   <= 1'b0;
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      pend_r <= issue_s;
      if (issue_s) begin
        pc_r      <= pc_r + PC_W'(1'b1);
        pend_pc_r <= pc_r;
      end
      if (push_s) begin
        instr_mem_r[wr_ptr_r] <= bus.imem_rdata;
        pc_mem_r[wr_ptr_r]    <= pend_pc_r;
        wr_ptr_r              <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
`ifdef HALT_DETECT_EN
      if (push_s && (bus.imem_rdata[INSTR_W-1 -: 3] == 3'b111)) begin
        state_r <= HALT;
      end
`endif
    end
  end

  assign bus.imem_req   = issue_s;
  assign bus.imem_addr  = pc_r;
  assign bus.if_valid   = (count_r != {CW{1'b0}});
  assign bus.if_instr   = instr_mem_r[rd_ptr_r];
  assign bus.if_pc      = pc_mem_r[rd_ptr_r];
  assign bus.fifo_count = count_r;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: table of per-cycle vectors plus
// hand-written async-reset and (with HALT_DETECT_EN) halt sequences.
module tb_instr_fetch_stage;
  localparam int PC_W       = 8;
  localparam int INSTR_W    = 32;
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  instr_fetch_stage_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  instr_fetch_stage #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .FIFO_DEPTH(FIFO_DEPTH), .RESET_PC(8'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [0:255];

  always_ff @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= imem[bus.imem_addr];
  end

  function automatic logic [31:0] img(input logic [7:0] a);
    logic [31:0] w;
    w = {7'd0, a, 17'd0};
    if (a == 8'h00) w = 32'h6402_0000;
    else if (a == 8'h01) w = 32'h0286_0000;
`ifdef HALT_DETECT_EN
    else if (a == 8'h03) w = 32'hE000_0000;
`endif
    return w;
  endfunction

  typedef struct {
    logic       rst_before;
    logic       rdy;
    logic       redir;
    logic [7:0] rpc;
    logic       req;
    logic [7:0] addr;
    logic       vld;
    logic [7:0] pc;
    logic [2:0] cnt;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(input logic rb, input logic rdy, input logic redir,
                              input logic [7:0] rpc, input logic req, input logic [7:0] addr,
                              input logic vld, input logic [7:0] pc, input logic [2:0] cnt);
    vec_t v;
    v.rst_before = rb; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
    v.req = req; v.addr = addr; v.vld = vld; v.pc = pc; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Holds reset for two cycles, checks reset values, releases at a negedge.
  task automatic do_reset();
    rst = 1'b1;
    bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 8'h00;
    #1;
    check("rst_req",   32'(bus.imem_req),   32'd0);
    check("rst_addr",  32'(bus.imem_addr),  32'd0);
    check("rst_valid", 32'(bus.if_valid),   32'd0);
    check("rst_instr", 32'(bus.if_instr),   32'd0);
    check("rst_pc",    32'(bus.if_pc),      32'd0);
    check("rst_count", 32'(bus.fifo_count), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = img(8'(i));
    bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 8'h00;

    // first fetch, id_ready held high
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 3'd0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 8'h00, 3'd0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'h00, 3'd1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 8'h01, 3'd1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 8'h02, 3'd1));
    // back-pressure from reset for 10 cycles
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 3'd0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 8'h00, 3'd0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'h00, 3'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 8'h00, 3'd2));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h04, 1'b1, 8'h00, 3'd3));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h04, 1'b1, 8'h00, 3'd4));
    // release back-pressure: in-order delivery, steady occupancy 3
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 8'h00, 3'd4));
    for (int i = 1; i <= 5; i++)
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'(i + 4), 1'b1, 8'(i), 3'd3));
    // redirect to 0x40 with 3 entries buffered and word 9 in flight
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 8'h0A, 1'b1, 8'h06, 3'd3));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0, 8'h00, 3'd0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0, 8'h00, 3'd0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h42, 1'b1, 8'h40, 3'd1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h43, 1'b1, 8'h41, 3'd1));
    // redirect to 0xFE: PC wraps
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'hFE, 1'b0, 8'h44, 1'b1, 8'h42, 3'd1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'hFE, 1'b0, 8'h00, 3'd0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 8'h00, 3'd0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'hFE, 3'd1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 8'hFF, 3'd1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'h00, 3'd1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 8'h01, 3'd1));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_before) do_reset();
      bus.id_ready       = vecs[i].rdy;
      bus.redirect_valid = vecs[i].redir;
      bus.redirect_pc    = vecs[i].rpc;
      #1;
      check($sformatf("v%0d_req", i),   32'(bus.imem_req),   32'(vecs[i].req));
      check($sformatf("v%0d_addr", i),  32'(bus.imem_addr),  32'(vecs[i].addr));
      check($sformatf("v%0d_valid", i), 32'(bus.if_valid),   32'(vecs[i].vld));
      check($sformatf("v%0d_count", i), 32'(bus.fifo_count), 32'(vecs[i].cnt));
      if (vecs[i].vld) begin
        check($sformatf("v%0d_pc", i),    32'(bus.if_pc), 32'(vecs[i].pc));
        check($sformatf("v%0d_instr", i), bus.if_instr,   img(vecs[i].pc));
      end
      @(negedge clk);
    end
    bus.redirect_valid = 1'b0;

    // async reset mid-stream with a full FIFO
    do_reset();
    bus.id_ready = 1'b0;
    repeat (6) @(negedge clk);
    check("full_count", 32'(bus.fifo_count), 32'd4);
    #2;
    rst = 1'b1;
    #1;
    check("async_valid", 32'(bus.if_valid),   32'd0);
    check("async_req",   32'(bus.imem_req),   32'd0);
    check("async_count", 32'(bus.fifo_count), 32'd0);
    check("async_addr",  32'(bus.imem_addr),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.id_ready = 1'b1;
    #1;
    check("restart_req",  32'(bus.imem_req),  32'd1);
    check("restart_addr", 32'(bus.imem_addr), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check("restart_valid", 32'(bus.if_valid), 32'd1);
    check("restart_pc",    32'(bus.if_pc),    32'd0);
    check("restart_instr", bus.if_instr,      32'h6402_0000);
    @(negedge clk);

`ifdef HALT_DETECT_EN
    begin
      int  max_addr;
      logic saw3;
      max_addr = 0;
      saw3 = 1'b0;
      do_reset();
      bus.id_ready = 1'b1;
      for (int c = 0; c < 14; c++) begin
        #1;
        if (bus.imem_req && (int'(bus.imem_addr) > max_addr)) max_addr = int'(bus.imem_addr);
        if (bus.if_valid && (bus.if_pc == 8'h03)) saw3 = 1'b1;
        @(negedge clk);
      end
      #1;
      check("halt_max_addr", 32'(max_addr), 32'd4);
      check("halt_saw3",     32'(saw3),     32'd1);
      check("halt_req",      32'(bus.imem_req), 32'd0);
      check("halt_valid",    32'(bus.if_valid), 32'd0);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 8'h00;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      #1;
      check("halt_redir_req",  32'(bus.imem_req),  32'd1);
      check("halt_redir_addr", 32'(bus.imem_addr), 32'd0);
      @(negedge clk);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
